capture_sequencer: RTL

//  Sequences the ADC->FIFO->FX3 streaming path: arms on FX3 start, waits for thread ready and FIFO prefill,

---
 rtl/capture_pkg.sv | 25 ++
 rtl/capture_counter.sv | 43 ++++
 rtl/capture_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: FSM state encoding, counter
// width and mode, and default sizing for the GPIF burst path.
package capture_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_BURST_LEN   = 8192;
  localparam int DEF_START_LEVEL = 2048;
  localparam int DEF_TURNAROUND  = 4;
  localparam int DEF_FIFO_AW     = 12;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_THREAD = 3'd1,
    ST_WAIT_LEVEL  = 3'd2,
    ST_BURST       = 3'd3,
    ST_TURN        = 3'd4
  } state_t;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_t;

endpackage

// File: rtl/capture_counter.sv
// Event counter with synchronous clear and enable. MODE selects whether the
// count rolls over to zero or sticks at all-ones. Clear has priority.
module capture_counter
  import capture_pkg::*;
#(
  parameter cnt_mode_t MODE = CNT_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, hold at ceiling when saturating, otherwise increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if ((MODE == CNT_SATURATE) && (count_q == '1)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: drives FX3 GPIF write bursts from the show-ahead FIFO
// read side. Optional stall statistics are built when CAPTURE_STATS_EN is
// defined; otherwise stall_count is a constant zero.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_IDLE        | host not armed; outputs quiet, counters held
// ST_WAIT_THREAD | armed, waiting for FX3 thread 0 buffer ready
// ST_WAIT_LEVEL  | waiting for FIFO prefill before starting a burst
// ST_BURST       | issuing writes; pauses (no abort) when a pop is unsafe
// ST_TURN        | fixed idle gap while FX3 switches DMA buffers
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int START_LEVEL = DEF_START_LEVEL,
  parameter int TURNAROUND  = DEF_TURNAROUND,
  parameter int FIFO_AW     = DEF_FIFO_AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fx3_nReady,
  input  logic               fx3_th0Ready,
  input  logic [FIFO_AW-1:0] fifo_usedWords,
  input  logic               fifo_full,
  output logic               fx3_nWrite,
  output logic               fifo_readAck,
  output logic               overflow_flag,
  output logic [CNT_W-1:0]   burst_count,
  output logic [CNT_W-1:0]   stall_count
);

  localparam int REM_W  = $clog2(BURST_LEN + 1);
  localparam int TURN_W = $clog2(TURNAROUND + 1);

  localparam logic [FIFO_AW-1:0] LEVEL_START = FIFO_AW'(START_LEVEL);
  localparam logic [FIFO_AW-1:0] LEVEL_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW-1:0] LEVEL_TWO   = FIFO_AW'(2);

  state_t            state_q, state_d;
  logic [REM_W-1:0]  remaining_q, remaining_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              read_ack_q, read_ack_d;
  logic              overflow_q, overflow_d;

  logic wr_en;
  logic arm_clr;
  logic burst_inc;

  // A single word left may only be popped if no pop is already in flight,
  // otherwise the show-ahead FIFO would be read empty.
  assign wr_en = !fx3_th0Ready &&
                 ((fifo_usedWords >= LEVEL_TWO) ||
                  ((fifo_usedWords == LEVEL_ONE) && !read_ack_q));

  // Next-state, burst bookkeeping and registered write strobe.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    turn_d      = turn_q;
    read_ack_d  = 1'b0;
    overflow_d  = overflow_q;
    arm_clr     = 1'b0;
    burst_inc   = 1'b0;

    if ((state_q != ST_IDLE) && fifo_full) begin
      overflow_d = 1'b1;
    end

    if (fx3_nReady) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT_THREAD;
          overflow_d = 1'b0;
          arm_clr    = 1'b1;
        end
        ST_WAIT_THREAD: begin
          if (!fx3_th0Ready) begin
            state_d = ST_WAIT_LEVEL;
          end
        end
        ST_WAIT_LEVEL: begin
          if (fifo_usedWords >= LEVEL_START) begin
            state_d     = ST_BURST;
            remaining_d = REM_W'(BURST_LEN);
          end
        end
        ST_BURST: begin
          if (wr_en) begin
            read_ack_d  = 1'b1;
            remaining_d = remaining_q - REM_W'(1);
            if (remaining_q == REM_W'(1)) begin
              state_d   = ST_TURN;
              turn_d    = TURN_W'(TURNAROUND);
              burst_inc = 1'b1;
            end
          end
        end
        ST_TURN: begin
          if (turn_q == TURN_W'(1)) begin
            state_d = ST_WAIT_THREAD;
          end else begin
            turn_d = turn_q - TURN_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      turn_q      <= '0;
      read_ack_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      turn_q      <= turn_d;
      read_ack_q  <= read_ack_d;
      overflow_q  <= overflow_d;
    end
  end

  // Both GPIF pins come from one flop so they can never disagree.
  assign fifo_readAck  = read_ack_q;
  assign fx3_nWrite    = !read_ack_q;
  assign overflow_flag = overflow_q;

  capture_counter #(
    .MODE (CNT_WRAP)
  ) u_burst_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (arm_clr),
    .en    (burst_inc),
    .count (burst_count)
  );

`ifdef CAPTURE_STATS_EN
  logic stall_en;

  assign stall_en = (state_q == ST_BURST) && !fx3_nReady && !wr_en;

  capture_counter #(
    .MODE (CNT_SATURATE)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (arm_clr),
    .en    (stall_en),
    .count (stall_count)
  );
`else
  assign stall_count = '0;
`endif

endmodule
